// File: rtl/apu_frame_counter_if.sv
// CPU-side bundle for the APU frame counter: cycle strobe, $4017 write,
// $4015 read strobe and the three frame outputs.
interface apu_frame_counter_if;
  logic       cpu_clk;
  logic       frame_wren;
  logic [7:0] from_cpu;
  logic       status_rd;
  logic       e_pulse;
  logic       l_pulse;
  logic       frame_irq;

  // CPU / bus side drives the strobes and samples the outputs
  modport master (
    output cpu_clk, frame_wren, from_cpu, status_rd,
    input  e_pulse, l_pulse, frame_irq
  );

  // frame counter side
  modport slave (
    input  cpu_clk, frame_wren, from_cpu, status_rd,
    output e_pulse, l_pulse, frame_irq
  );
endinterface

// File: rtl/apu_frame_counter.sv
// APU frame sequencer: 16-bit CPU-cycle step counter decoded into quarter-
// and half-frame pulses plus the 4-step frame IRQ. A $4017 write restarts the
// sequence WRITE_DELAY CPU cycles later; in 5-step mode that restart also
// fires an immediate quarter+half clock.
module apu_frame_counter #(
  parameter int WRITE_DELAY = 3
) (
  input logic               clk,
  input logic               rst,
  apu_frame_counter_if.slave bus
);

  localparam int PW = (WRITE_DELAY < 2) ? 1 : $clog2(WRITE_DELAY + 1);

  logic [15:0]   c;
  logic          mode;
  logic          irq_inhibit;
  logic [PW-1:0] pending;
  logic          quarter_q;
  logic          half_q;
  logic          irq_q;

  logic quarter_evt, half_evt, irq_evt, wrap, done, inhibit_eff;

  // decode the counter value as it stood before this cpu_clk edge
  always_comb begin
    quarter_evt = 1'b0;
    half_evt    = 1'b0;
    irq_evt     = 1'b0;
    wrap        = mode ? (c == 16'd37281) : (c == 16'd29829);
    if (bus.cpu_clk) begin
      quarter_evt = (c == 16'd7456) || (c == 16'd14912) || (c == 16'd22370) ||
                    (!mode && c == 16'd29828) || (mode && c == 16'd37280);
      half_evt    = (c == 16'd14912) ||
                    (!mode && c == 16'd29828) || (mode && c == 16'd37280);
      irq_evt     = !mode && ((c == 16'd29828) || (c == 16'd29829));
    end
    // a write on the same edge reloads the delay, so it cancels completion
    done        = bus.cpu_clk && !bus.frame_wren && (pending == PW'(1));
    // a coincident write's inhibit bit governs this edge's IRQ set
    inhibit_eff = bus.frame_wren ? bus.from_cpu[6] : irq_inhibit;
  end

  // sequencer, pending restart, registered pulses and the IRQ flag
  always_ff @(posedge clk) begin
    if (rst) begin
      c           <= '0;
      mode        <= 1'b0;
      irq_inhibit <= 1'b0;
      pending     <= '0;
      quarter_q   <= 1'b0;
      half_q      <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      quarter_q <= quarter_evt | (done & mode);
      half_q    <= half_evt    | (done & mode);

      if (bus.cpu_clk)
        c <= (done || wrap) ? 16'd0 : c + 16'd1;

      if (bus.frame_wren) begin
        mode        <= bus.from_cpu[7];
        irq_inhibit <= bus.from_cpu[6];
        pending     <= PW'(WRITE_DELAY);
      end else if (bus.cpu_clk && pending != '0) begin
        pending <= pending - PW'(1);
      end

      // write-clear beats set; set beats a status read
      if (bus.frame_wren && bus.from_cpu[6])
        irq_q <= 1'b0;
      else if (irq_evt && !inhibit_eff)
        irq_q <= 1'b1;
      else if (bus.status_rd)
        irq_q <= 1'b0;
    end
  end

  assign bus.e_pulse   = quarter_q;
  assign bus.l_pulse   = half_q;
  assign bus.frame_irq = irq_q;

endmodule
